// File: rtl/usb_obi_bridge_master.sv
// Byte-packet to OBI master bridge: parses CMD/ADDR/WDATA packets from the USB RX stream,
// performs one 32-bit OBI access per packet and returns ACK, read data or an error byte on TX.
module usb_obi_bridge_master #(
    parameter int unsigned RX_TIMEOUT = 1024,
    parameter logic [7:0]  ACK_BYTE   = 8'hA5,
    parameter logic [7:0]  ERR_BYTE   = 8'hEE
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        rx_valid_i,
    input  logic [7:0]  rx_data_i,
    output logic        rx_ready_o,
    output logic        tx_valid_o,
    output logic [7:0]  tx_data_o,
    input  logic        tx_ready_i,
    output logic        bus_req_o,
    output logic        bus_we_o,
    output logic [3:0]  bus_be_o,
    output logic [31:0] bus_addr_o,
    output logic [31:0] bus_wdata_o,
    input  logic        bus_gnt_i,
    input  logic        bus_rvalid_i,
    input  logic [31:0] bus_rdata_i,
    output logic        busy_o
);

    localparam int unsigned TO_W = (RX_TIMEOUT > 2) ? $clog2(RX_TIMEOUT) : 1;
    localparam logic [TO_W-1:0] TO_MAX = TO_W'(RX_TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ADDR,
        S_DATA,
        S_REQ,
        S_WAIT_R,
        S_RESP
    } state_e;

    state_e          state_q, state_d;
    logic [1:0]      cnt_q, cnt_d;
    logic [TO_W-1:0] to_q, to_d;
    logic            we_q, we_d;
    logic [31:0]     addr_q, addr_d;
    logic [31:0]     wdata_q, wdata_d;
    logic            req_q, req_d;
    logic            rx_rdy_q, rx_rdy_d;
    logic            tx_valid_q, tx_valid_d;
    logic [31:0]     tx_buf_q, tx_buf_d;
    logic [1:0]      tx_left_q, tx_left_d;
    logic            rx_fire;

    assign rx_fire = rx_valid_i && rx_rdy_q;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        to_d      = to_q;
        we_d      = we_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        tx_buf_d  = tx_buf_q;
        tx_left_d = tx_left_q;

        case (state_q)
            S_IDLE: begin
                if (rx_fire) begin
                    if (rx_data_i == 8'h01 || rx_data_i == 8'h02) begin
                        we_d    = (rx_data_i == 8'h01);
                        cnt_d   = 2'd0;
                        to_d    = '0;
                        state_d = S_ADDR;
                    end else begin
                        tx_buf_d  = {24'd0, ERR_BYTE};
                        tx_left_d = 2'd0;
                        state_d   = S_RESP;
                    end
                end
            end
            S_ADDR: begin
                if (rx_fire) begin
                    addr_d = {rx_data_i, addr_q[31:8]};
                    cnt_d  = cnt_q + 2'd1;
                    to_d   = '0;
                    if (cnt_q == 2'd3) begin
                        if (addr_d[1:0] != 2'b00) begin
                            tx_buf_d  = {24'd0, ERR_BYTE};
                            tx_left_d = 2'd0;
                            state_d   = S_RESP;
                        end else if (we_q) begin
                            state_d = S_DATA;
                        end else begin
                            state_d = S_REQ;
                        end
                    end
                end else if (to_q == TO_MAX) begin
                    tx_buf_d  = {24'd0, ERR_BYTE};
                    tx_left_d = 2'd0;
                    state_d   = S_RESP;
                end else begin
                    to_d = to_q + 1'b1;
                end
            end
            S_DATA: begin
                if (rx_fire) begin
                    wdata_d = {rx_data_i, wdata_q[31:8]};
                    cnt_d   = cnt_q + 2'd1;
                    to_d    = '0;
                    if (cnt_q == 2'd3) begin
                        state_d = S_REQ;
                    end
                end else if (to_q == TO_MAX) begin
                    tx_buf_d  = {24'd0, ERR_BYTE};
                    tx_left_d = 2'd0;
                    state_d   = S_RESP;
                end else begin
                    to_d = to_q + 1'b1;
                end
            end
            S_REQ: begin
                if (bus_gnt_i) begin
                    if (bus_rvalid_i) begin
                        tx_buf_d  = we_q ? {24'd0, ACK_BYTE} : bus_rdata_i;
                        tx_left_d = we_q ? 2'd0 : 2'd3;
                        state_d   = S_RESP;
                    end else begin
                        state_d = S_WAIT_R;
                    end
                end
            end
            S_WAIT_R: begin
                if (bus_rvalid_i) begin
                    tx_buf_d  = we_q ? {24'd0, ACK_BYTE} : bus_rdata_i;
                    tx_left_d = we_q ? 2'd0 : 2'd3;
                    state_d   = S_RESP;
                end
            end
            S_RESP: begin
                if (tx_ready_i) begin
                    if (tx_left_q == 2'd0) begin
                        state_d = S_IDLE;
                    end else begin
                        tx_buf_d  = {8'd0, tx_buf_q[31:8]};
                        tx_left_d = tx_left_q - 2'd1;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Handshake outputs are registered copies of the upcoming state.
        req_d      = (state_d == S_REQ);
        tx_valid_d = (state_d == S_RESP);
        rx_rdy_d   = (state_d == S_IDLE) || (state_d == S_ADDR) || (state_d == S_DATA);
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q    <= S_IDLE;
            cnt_q      <= 2'd0;
            to_q       <= '0;
            we_q       <= 1'b0;
            addr_q     <= 32'd0;
            wdata_q    <= 32'd0;
            req_q      <= 1'b0;
            rx_rdy_q   <= 1'b0;
            tx_valid_q <= 1'b0;
            tx_buf_q   <= 32'd0;
            tx_left_q  <= 2'd0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            to_q       <= to_d;
            we_q       <= we_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            req_q      <= req_d;
            rx_rdy_q   <= rx_rdy_d;
            tx_valid_q <= tx_valid_d;
            tx_buf_q   <= tx_buf_d;
            tx_left_q  <= tx_left_d;
        end
    end

    assign rx_ready_o  = rx_rdy_q;
    assign tx_valid_o  = tx_valid_q;
    assign tx_data_o   = tx_buf_q[7:0];
    assign bus_req_o   = req_q;
    assign bus_we_o    = we_q;
    assign bus_be_o    = 4'hF;
    assign bus_addr_o  = addr_q;
    assign bus_wdata_o = wdata_q;
    assign busy_o      = (state_q != S_IDLE);

endmodule

// File: tb/tb_usb_obi_bridge_master.sv
// Randomized bench for usb_obi_bridge_master: drives packets, plays the OBI slave and
// compares bus accesses and reply bytes with a packet-level reference model.
module tb_usb_obi_bridge_master;

    localparam int TO = 16;

    logic        clk = 1'b0;
    logic        rst_i;
    logic        rx_valid_i;
    logic [7:0]  rx_data_i;
    logic        rx_ready_o;
    logic        tx_valid_o;
    logic [7:0]  tx_data_o;
    logic        tx_ready_i;
    logic        bus_req_o;
    logic        bus_we_o;
    logic [3:0]  bus_be_o;
    logic [31:0] bus_addr_o;
    logic [31:0] bus_wdata_o;
    logic        bus_gnt_i;
    logic        bus_rvalid_i;
    logic [31:0] bus_rdata_i;
    logic        busy_o;

    int n_chk = 0;
    int n_pass = 0;
    int gnt_seen = 0;
    int gnt_exp = 0;
    logic [7:0] exp_reply[$];

    usb_obi_bridge_master #(.RX_TIMEOUT(TO), .ACK_BYTE(8'hA5), .ERR_BYTE(8'hEE)) dut (
        .clk_i(clk), .rst_i(rst_i),
        .rx_valid_i(rx_valid_i), .rx_data_i(rx_data_i), .rx_ready_o(rx_ready_o),
        .tx_valid_o(tx_valid_o), .tx_data_o(tx_data_o), .tx_ready_i(tx_ready_i),
        .bus_req_o(bus_req_o), .bus_we_o(bus_we_o), .bus_be_o(bus_be_o),
        .bus_addr_o(bus_addr_o), .bus_wdata_o(bus_wdata_o),
        .bus_gnt_i(bus_gnt_i), .bus_rvalid_i(bus_rvalid_i), .bus_rdata_i(bus_rdata_i),
        .busy_o(busy_o)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (bus_req_o && bus_gnt_i) gnt_seen <= gnt_seen + 1;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got running required finished");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    // Called at a negedge; returns at the negedge after the byte was taken.
    task automatic send_byte(input logic [7:0] b, input int gap);
        int n;
        repeat (gap) @(negedge clk);
        rx_valid_i = 1'b1;
        rx_data_i  = b;
        n = 0;
        while (!rx_ready_o && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) check("rx_accept_bound", 0, 1);
        @(negedge clk);
        rx_valid_i = 1'b0;
    endtask

    task automatic do_bus(input logic [31:0] addr, input logic we, input logic [31:0] wdata,
                          input int gnt_dly, input int rv_dly, input logic [31:0] rdata);
        check("req_latency", bus_req_o, 1);
        check("bus_addr", bus_addr_o, addr);
        check("bus_we", bus_we_o, we);
        check("bus_be", bus_be_o, 4'hF);
        if (we) check("bus_wdata", bus_wdata_o, wdata);
        repeat (gnt_dly) begin
            @(negedge clk);
            check("req_held", bus_req_o, 1);
            check("addr_stable", bus_addr_o, addr);
        end
        bus_gnt_i = 1'b1;
        gnt_exp++;
        if (rv_dly == 0) begin
            bus_rvalid_i = 1'b1;
            bus_rdata_i  = rdata;
        end else begin
            bus_rdata_i = $urandom;
        end
        @(negedge clk);
        bus_gnt_i    = 1'b0;
        bus_rvalid_i = 1'b0;
        bus_rdata_i  = $urandom;
        check("req_drop", bus_req_o, 0);
        if (rv_dly > 0) begin
            check("no_early_tx", tx_valid_o, 0);
            repeat (rv_dly - 1) @(negedge clk);
            bus_rvalid_i = 1'b1;
            bus_rdata_i  = rdata;
            @(negedge clk);
            bus_rvalid_i = 1'b0;
            bus_rdata_i  = $urandom;
        end
        check("rvalid_to_tx", tx_valid_o, 1);
    endtask

    task automatic collect_reply(input int bp_at, input int bp_len);
        for (int i = 0; i < exp_reply.size(); i++) begin
            int n;
            n = 0;
            while (!tx_valid_o && n < 4 * TO + 50) begin
                @(negedge clk);
                n++;
            end
            check("tx_valid", tx_valid_o, 1);
            check("tx_byte", tx_data_o, exp_reply[i]);
            check("no_req_in_reply", bus_req_o, 0);
            if (i == bp_at) begin
                for (int k = 0; k < bp_len; k++) begin
                    @(negedge clk);
                    check("bp_data_stable", tx_data_o, exp_reply[i]);
                    check("bp_rx_ready", rx_ready_o, 0);
                end
            end
            tx_ready_i = 1'b1;
            @(negedge clk);
            tx_ready_i = 1'b0;
        end
        check("busy_after_reply", busy_o, 0);
        check("tx_idle_after_reply", tx_valid_o, 0);
    endtask

    task automatic run_txn(input logic [7:0] cmd, input logic [31:0] addr, input logic [31:0] wdata,
                           input int gnt_dly, input int rv_dly, input logic [31:0] rdata,
                           input int bp_at, input int bp_len, input int max_gap);
        logic [7:0] b;
        bit bad_cmd, misal, wr;
        bad_cmd = !(cmd == 8'h01 || cmd == 8'h02);
        misal   = (addr[1:0] != 2'b00);
        wr      = (cmd == 8'h01);
        exp_reply.delete();
        send_byte(cmd, $urandom_range(0, max_gap));
        if (!bad_cmd) begin
            for (int i = 0; i < 4; i++) begin
                b = addr[8*i +: 8];
                send_byte(b, $urandom_range(0, max_gap));
            end
            if (!misal && wr) begin
                for (int i = 0; i < 4; i++) begin
                    b = wdata[8*i +: 8];
                    send_byte(b, $urandom_range(0, max_gap));
                end
            end
        end
        if (bad_cmd || misal) begin
            check("err_no_req", bus_req_o, 0);
            exp_reply.push_back(8'hEE);
        end else begin
            do_bus(addr, wr, wdata, gnt_dly, rv_dly, rdata);
            if (wr) exp_reply.push_back(8'hA5);
            else for (int i = 0; i < 4; i++) exp_reply.push_back(rdata[8*i +: 8]);
        end
        collect_reply(bp_at, bp_len);
    endtask

    initial begin
        logic [7:0]  cmd;
        logic [31:0] addr;
        rst_i = 1'b1;
        rx_valid_i = 1'b0;
        rx_data_i = 8'h00;
        tx_ready_i = 1'b0;
        bus_gnt_i = 1'b0;
        bus_rvalid_i = 1'b0;
        bus_rdata_i = 32'h0;
        repeat (3) @(negedge clk);
        check("rst_rx_ready", rx_ready_o, 0);
        check("rst_tx_valid", tx_valid_o, 0);
        check("rst_req", bus_req_o, 0);
        check("rst_busy", busy_o, 0);
        check("rst_addr", bus_addr_o, 0);
        rst_i = 1'b0;
        @(negedge clk);
        check("idle_rx_ready", rx_ready_o, 1);

        // Directed cases
        run_txn(8'h01, 32'hF000_0000, 32'hDEAD_BEEF, 3, 1, 32'h0, -1, 0, 0);
        run_txn(8'h02, 32'h0000_1000, 32'h0, 0, 2, 32'h1234_5678, -1, 0, 0);
        run_txn(8'h7F, 32'h0, 32'h0, 0, 0, 32'h0, -1, 0, 0);
        run_txn(8'h02, 32'h0000_0002, 32'h0, 0, 0, 32'h0, -1, 0, 0);
        run_txn(8'h02, 32'h0000_2000, 32'h0, 1, 0, 32'hCAFE_F00D, 1, 10, 0);

        // RX timeout after a partial packet
        send_byte(8'h01, 0);
        send_byte(8'h00, 0);
        repeat (TO - 1) @(negedge clk);
        check("to_not_yet", tx_valid_o, 0);
        check("to_rx_ready", rx_ready_o, 1);
        @(negedge clk);
        check("to_fire", tx_valid_o, 1);
        exp_reply.delete();
        exp_reply.push_back(8'hEE);
        collect_reply(-1, 0);
        run_txn(8'h02, 32'h0000_0040, 32'h0, 2, 1, 32'hA1B2_C3D4, -1, 0, 1);

        // Reset while the request is pending
        send_byte(8'h01, 0);
        send_byte(8'h00, 0);
        send_byte(8'h00, 0);
        send_byte(8'h00, 0);
        send_byte(8'hF0, 0);
        send_byte(8'h11, 0);
        send_byte(8'h22, 0);
        send_byte(8'h33, 0);
        send_byte(8'h44, 0);
        @(negedge clk);
        check("pre_rst_req", bus_req_o, 1);
        rst_i = 1'b1;
        #1;
        check("arst_req", bus_req_o, 0);
        check("arst_busy", busy_o, 0);
        check("arst_tx", tx_valid_o, 0);
        check("arst_wdata", bus_wdata_o, 0);
        repeat (2) @(negedge clk);
        rst_i = 1'b0;
        repeat (5) begin
            @(negedge clk);
            check("no_reply_after_rst", tx_valid_o, 0);
        end
        run_txn(8'h01, 32'hF000_0000, 32'hDEAD_BEEF, 3, 1, 32'h0, -1, 0, 0);

        // Randomized packets
        for (int t = 0; t < 30; t++) begin
            if ($urandom_range(0, 9) == 0) cmd = 8'h10 + 8'($urandom_range(0, 200));
            else cmd = ($urandom_range(0, 1) == 1) ? 8'h01 : 8'h02;
            addr = $urandom;
            if ($urandom_range(0, 3) != 0) addr[1:0] = 2'b00;
            run_txn(cmd, addr, $urandom, $urandom_range(0, 4), $urandom_range(0, 3), $urandom,
                    $urandom_range(0, 3), $urandom_range(0, 4), 3);
        end

        check("grant_count", gnt_seen, gnt_exp);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
